// File: rtl/ifu_ifc_seq.sv
// ifu_ifc_seq: IFU fetch-pipe sequencer.
// Issues F1/F2 fetch requests and arbitrates the next fetch address between
// flush, miss replay, predictor redirect and sequential fetch. A credit
// counter meters the fetch buffer.
// Optional feature macro: RV_IFC_PMU_CNT_EN enables the saturating
// stall-cycle counter pmu_stall_cnt. When it is undefined, the counter
// output is tied to zero.
module ifu_ifc_seq #(
  parameter int unsigned FB_DEPTH    = 4,
  parameter int unsigned FETCH_BYTES = 8,
  parameter logic [31:0] RESET_VEC   = 32'h0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush_valid,
  input  logic                               flush_halt,
  input  logic [30:0]                        flush_addr,
  input  logic                               bp_redirect_f2,
  input  logic [30:0]                        bp_target_f2,
  input  logic                               ic_hit_f2,
  input  logic                               ic_miss_done,
  input  logic                               fetch_stall,
  input  logic [1:0]                         fb_consume,
  output logic                               fetch_req_f1,
  output logic [30:0]                        fetch_addr_f1,
  output logic                               fetch_req_f2,
  output logic [30:0]                        fetch_addr_f2,
  output logic [$clog2(FB_DEPTH+1)-1:0]      fb_used,
  output logic [1:0]                         fetch_state,
  output logic                               pmu_fetch_stall,
  output logic [15:0]                        pmu_stall_cnt,
  input  logic                               pmu_clr
);

  localparam int unsigned AW  = 31;
  localparam int unsigned FBW = $clog2(FB_DEPTH + 1);
  localparam int unsigned CW  = FBW + 2;
  localparam int unsigned OFF = $clog2(FETCH_BYTES) - 1;
  localparam int unsigned SW  = AW - OFF;
  localparam logic [AW-1:0] RST_ADDR = RESET_VEC[31:1];

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    WFM   = 2'b11
  } state_t;

  state_t          state;
  logic            boot;
  logic            req_f2_q;
  logic [AW-1:0]   replay_addr;

  logic            f1_pending;
  logic            miss_f2;
  logic            redirect;
  logic            miss_exit;
  logic            credit_ok;
  logic            issue;
  logic [CW-1:0]   used_ext;
  logic [CW-1:0]   cons_ext;
  logic [CW-1:0]   avail;
  logic [CW-1:0]   add_v;
  logic [CW-1:0]   sub_v;
  logic [AW-1:0]   seq_addr;

  // Issue qualification, miss/redirect decode and credit arithmetic.
  always_comb begin
    f1_pending      = (state == FETCH);
    fetch_req_f2    = req_f2_q & ~flush_valid & ~rst;
    miss_f2         = fetch_req_f2 & ~ic_hit_f2;
    redirect        = bp_redirect_f2 & fetch_req_f2 & ~miss_f2;
    miss_exit       = (state == WFM) & ic_miss_done;
    used_ext        = CW'(fb_used);
    cons_ext        = CW'(fb_consume);
    // Consumption beyond current occupancy clamps to zero.
    avail           = (cons_ext > used_ext) ? '0 : (used_ext - cons_ext);
    credit_ok       = (avail < CW'(FB_DEPTH));
    issue           = f1_pending & ~rst & ~fetch_stall & ~bp_redirect_f2 &
                      ~miss_f2 & ~flush_valid & credit_ok;
    fetch_req_f1    = issue;
    pmu_fetch_stall = ~rst & ~flush_valid & ~bp_redirect_f2 &
                      ((state == WFM) | (f1_pending & ~issue));
    add_v           = used_ext + CW'(issue);
    sub_v           = cons_ext + CW'(miss_f2);
    seq_addr        = {fetch_addr_f1[AW-1:OFF] + SW'(1), {OFF{1'b0}}};
    fetch_state     = state;
  end

  // Fetch FSM, address pipeline, replay capture and credit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      boot          <= 1'b1;
      req_f2_q      <= 1'b0;
      fetch_addr_f1 <= RST_ADDR;
      fetch_addr_f2 <= RST_ADDR;
      replay_addr   <= RST_ADDR;
      fb_used       <= '0;
    end else begin
      boot     <= 1'b0;
      req_f2_q <= issue;

      if (issue) fetch_addr_f2 <= fetch_addr_f1;
      if (miss_f2) replay_addr <= fetch_addr_f2;

      if (flush_valid)    fetch_addr_f1 <= flush_addr;
      else if (miss_exit) fetch_addr_f1 <= replay_addr;
      else if (redirect)  fetch_addr_f1 <= bp_target_f2;
      else if (issue)     fetch_addr_f1 <= seq_addr;

      if (flush_valid) fb_used <= '0;
      else             fb_used <= FBW'((add_v > sub_v) ? (add_v - sub_v) : '0);

      if (flush_valid) begin
        state <= flush_halt ? IDLE : FETCH;
      end else begin
        case (state)
          IDLE:    if (boot) state <= FETCH;
          FETCH:   if (miss_f2) state <= WFM;
          WFM:     if (ic_miss_done) state <= FETCH;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef RV_IFC_PMU_CNT_EN
  // Saturating stall-cycle counter; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst || pmu_clr) begin
      pmu_stall_cnt <= '0;
    end else if (pmu_fetch_stall && (pmu_stall_cnt != 16'hFFFF)) begin
      pmu_stall_cnt <= pmu_stall_cnt + 16'd1;
    end
  end
`else
  logic unused_pmu_clr;
  assign unused_pmu_clr = pmu_clr;
  assign pmu_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_ifu_ifc_seq.sv
// Directed bench for ifu_ifc_seq with default parameters (FB_DEPTH=4,
// FETCH_BYTES=8, RESET_VEC=0). The bench queues the expected F2 addresses
// when it expects an F1 issue and pops them on the following cycle.
module tb_ifu_ifc_seq;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_FETCH = 2'b01;
  localparam logic [1:0] S_WFM   = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_valid, flush_halt;
  logic [30:0] flush_addr;
  logic        bp_redirect_f2;
  logic [30:0] bp_target_f2;
  logic        ic_hit_f2, ic_miss_done, fetch_stall;
  logic [1:0]  fb_consume;
  logic        fetch_req_f1, fetch_req_f2;
  logic [30:0] fetch_addr_f1, fetch_addr_f2;
  logic [2:0]  fb_used;
  logic [1:0]  fetch_state;
  logic        pmu_fetch_stall;
  logic [15:0] pmu_stall_cnt;
  logic        pmu_clr;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] f2_q[$];
  logic [15:0] exp_cnt  = 16'd0;

  always #5 clk = ~clk;

  ifu_ifc_seq dut (
    .clk            (clk),
    .rst            (rst),
    .flush_valid    (flush_valid),
    .flush_halt     (flush_halt),
    .flush_addr     (flush_addr),
    .bp_redirect_f2 (bp_redirect_f2),
    .bp_target_f2   (bp_target_f2),
    .ic_hit_f2      (ic_hit_f2),
    .ic_miss_done   (ic_miss_done),
    .fetch_stall    (fetch_stall),
    .fb_consume     (fb_consume),
    .fetch_req_f1   (fetch_req_f1),
    .fetch_addr_f1  (fetch_addr_f1),
    .fetch_req_f2   (fetch_req_f2),
    .fetch_addr_f2  (fetch_addr_f2),
    .fb_used        (fb_used),
    .fetch_state    (fetch_state),
    .pmu_fetch_stall(pmu_fetch_stall),
    .pmu_stall_cnt  (pmu_stall_cnt),
    .pmu_clr        (pmu_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic defaults();
    flush_valid    = 1'b0;
    flush_halt     = 1'b0;
    flush_addr     = '0;
    bp_redirect_f2 = 1'b0;
    bp_target_f2   = '0;
    ic_hit_f2      = 1'b1;
    ic_miss_done   = 1'b0;
    fetch_stall    = 1'b0;
    fb_consume     = 2'd0;
    pmu_clr        = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, then advance past the next edge.
  task automatic cyc(input logic e_req, input logic [31:0] e_addr, input int e_used,
                     input logic [1:0] e_state, input logic e_stall);
    logic [31:0] a;
    @(negedge clk);
    chk("req_f1",    32'(fetch_req_f1),    32'(e_req));
    chk("addr_f1",   {1'b0, fetch_addr_f1} << 1, e_addr);
    chk("fb_used",   32'(fb_used),         32'(e_used));
    chk("state",     32'(fetch_state),     32'(e_state));
    chk("pmu_stall", 32'(pmu_fetch_stall), 32'(e_stall));
`ifdef RV_IFC_PMU_CNT_EN
    chk("pmu_cnt",   32'(pmu_stall_cnt),   32'(exp_cnt));
`else
    chk("pmu_cnt",   32'(pmu_stall_cnt),   32'd0);
`endif
    if (f2_q.size() > 0) begin
      a = f2_q.pop_front();
      if (flush_valid || rst) begin
        chk("req_f2_killed", 32'(fetch_req_f2), 32'd0);
      end else begin
        chk("req_f2",  32'(fetch_req_f2), 32'd1);
        chk("addr_f2", {1'b0, fetch_addr_f2} << 1, a);
      end
    end else begin
      chk("req_f2_idle", 32'(fetch_req_f2), 32'd0);
    end
    if (e_req) f2_q.push_back(e_addr);
    if (rst || pmu_clr)                   exp_cnt = 16'd0;
    else if (e_stall && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    @(posedge clk);
    #1;
    defaults();
  endtask

  initial begin
    defaults();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    cyc(0, 32'h0, 0, S_IDLE, 0);
    rst = 1'b0;
    cyc(0, 32'h0, 0, S_IDLE, 0);

    // Streaming with consume=2: one sequential F1 per cycle.
    for (int i = 0; i < 6; i++) begin
      fb_consume = 2'd2;
      cyc(1, 32'(i * 8), 0, S_FETCH, 0);
    end

    // No consume: buffer fills to FB_DEPTH, then stalls.
    cyc(1, 32'h30, 0, S_FETCH, 0);
    cyc(1, 32'h38, 1, S_FETCH, 0);
    cyc(1, 32'h40, 2, S_FETCH, 0);
    cyc(1, 32'h48, 3, S_FETCH, 0);
    cyc(0, 32'h50, 4, S_FETCH, 1);
    cyc(0, 32'h50, 4, S_FETCH, 1);
    fb_consume = 2'd1;
    cyc(1, 32'h50, 4, S_FETCH, 0);
    cyc(0, 32'h58, 4, S_FETCH, 1);

    // F2 miss, WFM, replay.
    fb_consume = 2'd2;
    cyc(1, 32'h58, 4, S_FETCH, 0);
    ic_hit_f2 = 1'b0;
    cyc(0, 32'h60, 3, S_FETCH, 1);
    cyc(0, 32'h60, 2, S_WFM, 1);
    ic_miss_done = 1'b1;
    cyc(0, 32'h60, 2, S_WFM, 1);
    cyc(1, 32'h58, 2, S_FETCH, 0);

    // Redirect drops the current F1; then redirect together with a miss.
    bp_redirect_f2 = 1'b1;
    bp_target_f2   = 31'(32'h1230 >> 1);
    cyc(0, 32'h60, 3, S_FETCH, 0);
    cyc(1, 32'h1230, 3, S_FETCH, 0);
    ic_hit_f2      = 1'b0;
    bp_redirect_f2 = 1'b1;
    bp_target_f2   = 31'(32'h5550 >> 1);
    cyc(0, 32'h1238, 4, S_FETCH, 0);
    cyc(0, 32'h1238, 3, S_WFM, 1);

    // Halting flush, idle with over-consume, then refetch flush.
    flush_valid = 1'b1;
    flush_halt  = 1'b1;
    flush_addr  = 31'(32'h7770 >> 1);
    cyc(0, 32'h1238, 3, S_WFM, 0);
    fb_consume = 2'd2;
    cyc(0, 32'h7770, 0, S_IDLE, 0);
    flush_valid = 1'b1;
    flush_addr  = 31'(32'h2000 >> 1);
    cyc(0, 32'h7770, 0, S_IDLE, 0);
    cyc(1, 32'h2000, 0, S_FETCH, 0);

    // Flush kills in-flight F2; sequential address wraps past the top.
    flush_valid = 1'b1;
    flush_addr  = 31'(32'hFFFF_FFF0 >> 1);
    cyc(0, 32'h2008, 1, S_FETCH, 0);
    cyc(1, 32'hFFFF_FFF0, 0, S_FETCH, 0);
    cyc(1, 32'hFFFF_FFF8, 1, S_FETCH, 0);
    cyc(1, 32'h0, 2, S_FETCH, 0);

    // Reset mid-operation drops the in-flight request.
    rst = 1'b1;
    cyc(0, 32'h8, 3, S_FETCH, 0);
    rst = 1'b0;
    cyc(0, 32'h0, 0, S_IDLE, 0);
    cyc(1, 32'h0, 0, S_FETCH, 0);
    fetch_stall = 1'b1;
    cyc(0, 32'h8, 1, S_FETCH, 1);

`ifdef RV_IFC_PMU_CNT_EN
    // Long stall saturates the counter; clear wins over increment.
    fetch_stall = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    exp_cnt     = 16'hFFFF;
    fetch_stall = 1'b1;
    cyc(0, 32'h8, 1, S_FETCH, 1);
    fetch_stall = 1'b1;
    pmu_clr     = 1'b1;
    cyc(0, 32'h8, 1, S_FETCH, 1);
    fetch_stall = 1'b1;
    cyc(0, 32'h8, 1, S_FETCH, 1);
    cyc(1, 32'h8, 1, S_FETCH, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_ifc_seq.md
# ifu_ifc_seq

Parametrised fetch-pipe sequencer for the IFU, the next-generation fetch control with configurable fetch-buffer depth, fetch-block size and reset vector. It generates F1/F2 fetch requests and addresses, arbitrates flush, branch-predictor redirect, miss replay and sequential fetch, and meters the fetch buffer with a credit counter instead of a one-hot shift register. It sits between the TLU/EXU flush sources, the branch predictor, the I-cache/ICCM access path and the aligner.

## Interface
- FB_DEPTH, 4, number of fetch-buffer entries; 2..8
- FETCH_BYTES, 8, bytes per fetch block; power of two, 4..32; sequential increment granule
- RESET_VEC, 32'h0, reset fetch address; bit 0 ignored
- clk  in  1  core clock; the only clock
- rst  in  1  synchronous, active-high reset
- flush_valid  in  1  flush from TLU/EXU
- flush_halt  in  1  qualifies flush_valid: flush without refetch, go IDLE
- flush_addr  in  31  flush target [31:1]
- bp_redirect_f2  in  1  predictor taken hit on the F2 fetch
- bp_target_f2  in  31  predicted target [31:1]
- ic_hit_f2  in  1  F2 fetch data valid
- ic_miss_done  in  1  miss fill complete, replay allowed
- fetch_stall  in  1  DMA / cache-write stall, blocks F1 issue
- fb_consume  in  2  buffers freed by aligner this cycle, 0..2
- fetch_req_f1  out  1  F1 request issued
- fetch_addr_f1  out  31  F1 address
- fetch_req_f2  out  1  F2 request valid
- fetch_addr_f2  out  31  F2 address
- fb_used  out  $clog2(FB_DEPTH+1)  occupied plus in-flight buffer count
- fetch_state  out  2  IDLE=00, FETCH=01, WFM=11
- pmu_fetch_stall  out  1  cycle lost to stall, credits or WFM
- pmu_stall_cnt  out  16  saturating stall-cycle count (see Configuration)
- pmu_clr  in  1  clears pmu_stall_cnt

## Operation
- FSM: IDLE -> FETCH one cycle after rst deasserts, or on flush_valid & ~flush_halt. FETCH -> WFM on F2 miss (fetch_req_f2 & ~ic_hit_f2). WFM -> FETCH on ic_miss_done. Any state -> IDLE on flush_valid & flush_halt.
- Issue: fetch_req_f1 = f1_pending & state==FETCH & ~fetch_stall & ~bp_redirect_f2 & ~miss_f2 & ~flush_valid & (fb_used - fb_consume < FB_DEPTH).
- Next-F1-address priority: flush_addr > miss replay address (WFM exit) > bp_target_f2 > sequential (issued) > hold current (not issued).
- Sequential: {fetch_addr_f1[31:log2(FETCH_BYTES)] + 1, zeros}; wraps 0xFFFF_FFF8 -> 0x0 (FETCH_BYTES=8); carry dropped.
- F2: fetch_req_f2 = registered fetch_req_f1, killed same cycle by flush_valid. fetch_addr_f2 loads only on issue.
- Miss: F2 address captured as replay address; F1 killed; bp_redirect_f2 ignored that cycle (miss wins).
- Credits: fb_used_next = fb_used + issue - fb_consume - miss_f2; flush forces 0. fb_consume exceeding fb_used is clamped to 0 (never underflows); never exceeds FB_DEPTH.
- pmu_fetch_stall = WFM, or FETCH with f1_pending and no issue, excluding flush and redirect cycles.

## Timing
- Reset values: fetch_state IDLE, fetch_req_f1/f2 0, fetch_addr_f1/f2 RESET_VEC[31:1], fb_used 0, pmu_stall_cnt 0, pmu_fetch_stall 0.
- First fetch: cycle after rst low -> FETCH; following cycle fetch_req_f1=1 at RESET_VEC.
- Flush at cycle N: F1/F2 killed in N; fetch_req_f1 at flush_addr in N+1 (if credits).
- Redirect at N: F1 at bp_target_f2 in N+1.
- ic_miss_done at N: FETCH in N+1, replay F1 in N+1.
- F1 -> F2: exactly one cycle. rst mid-operation clears everything next edge; in-flight requests dropped.

## Configuration
- RV_IFC_PMU_CNT_EN defined: pmu_stall_cnt increments on pmu_fetch_stall, saturates at 0xFFFF, pmu_clr wins over increment.
- Undefined: counter absent, pmu_stall_cnt tied 0; pmu_fetch_stall still driven.

## Test plan
- Reset release, consume=2 every cycle -> F1 at 0x0,0x8,0x10,... (RESET_VEC=0, FETCH_BYTES=8), one per cycle, fb_used <= 2.
- No consume, FB_DEPTH=4 -> exactly 4 issues, fetch_req_f1 low, fb_used=4, pmu_fetch_stall high; one consume=1 -> one more issue.
- F2 miss at 0x40 -> WFM, F1 killed, fb_used decremented; ic_miss_done -> next-cycle F1 at 0x40.
- bp_redirect_f2 with target 0x1230 while F1 at 0x48 -> F1 at 0x48 dropped, next F1 at 0x1230; same cycle with miss -> redirect ignored, WFM.
- flush_valid+flush_halt -> IDLE, no requests, fb_used 0; later flush to 0x2000 -> F1 at 0x2000 next cycle.
- F1 at 0xFFFF_FFF8 with credits -> next F1 at 0x0; with macro, 70000 stall cycles -> pmu_stall_cnt=0xFFFF, pmu_clr -> 0.
